ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/ifetch_if.sv | 10 +
 rtl/ifetch_pc_reg.sv | 21 ++
 rtl/ifetch.sv | 88 ++++++++
 tb/tb_ifetch.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared reset address, FSM encoding and MIPS-style instruction field positions for ifetch.
package ifetch_pkg;
    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    typedef enum logic [1:0] {S_REQ, S_FULL, S_DROP} state_t;
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: instruction memory bus (req/addr out of the fetch unit, ack/rdata back from memory).
// Modports: master = fetch unit, slave = instruction memory.
interface ifetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/ifetch_pc_reg.sv
// pc_reg: program counter with load (word-aligned), +4 increment and sync active-low reset.
// Ports: clk, rst_n; ld/ld_val load request and target; inc advance by 4; pc current value.
module pc_reg #(
    parameter logic [31:0] RST_VAL = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld,
    input  logic [31:0] ld_val,
    input  logic        inc,
    output logic [31:0] pc
);
    always_ff @(posedge clk) begin
        if (!rst_n)
            pc <= RST_VAL;
        else if (ld)
            pc <= {ld_val[31:2], 2'b00};
        else if (inc)
            pc <= pc + 32'd4;
    end
endmodule

// File: rtl/ifetch.sv
// ifetch: single-outstanding instruction fetch unit with instruction register and decode fields.
// Ports: clk, rst_n (sync active-low); imem (ifetch_if.master) fetch bus; out_valid/out_ready
// instruction handshake; instr/pc_out IR and its address; op/rs/rt/rd/funct/imm16 decoded fields;
// redirect/redirect_pc change the fetch stream only when IFETCH_REDIRECT_EN is defined.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    ifetch_if.master    imem,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    state_t      state, state_nx;
    logic [31:0] pc, redir_pc;
    logic        redir, take;
`ifdef IFETCH_REDIRECT_EN
    assign redir    = redirect;
    assign redir_pc = redirect_pc;
`else
    logic unused_redirect;
    assign redir    = 1'b0;
    assign redir_pc = '0;
    assign unused_redirect = ^{redirect, redirect_pc};
`endif
    // Only an ack to a live request is accepted; acks in S_FULL are ignored, in S_DROP discarded.
    assign take = state == S_REQ && imem.ack;
    pc_reg #(.RST_VAL(PC_RESET)) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (redir),
        .ld_val (redir_pc),
        .inc    (take),
        .pc     (pc)
    );
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_REQ;
        else
            state <= state_nx;
    end
    // An ack that lands while the IR holds an unaccepted instruction stops further requests.
    always_comb begin
        state_nx = state;
        case (state)
            S_REQ:   state_nx = redir ? (imem.ack ? S_REQ : S_DROP)
                              : (imem.ack && out_valid && !out_ready) ? S_FULL : S_REQ;
            S_FULL:  state_nx = (redir || out_ready) ? S_REQ : S_FULL;
            default: state_nx = imem.ack ? S_REQ : S_DROP;
        endcase
    end
    // The request is masked during the reset cycle itself.
    assign imem.req  = rst_n && state == S_REQ;
    assign imem.addr = {pc[31:2], 2'b00};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            instr     <= '0;
            pc_out    <= '0;
        end else if (redir) begin
            out_valid <= 1'b0;
        end else if (take) begin
            instr     <= imem.rdata;
            pc_out    <= {pc[31:2], 2'b00};
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
    assign op    = instr[OP_MSB:OP_LSB];
    assign rs    = instr[RS_MSB:RS_LSB];
    assign rt    = instr[RT_MSB:RT_LSB];
    assign rd    = instr[RD_MSB:RD_LSB];
    assign funct = instr[FUNCT_MSB:FUNCT_LSB];
    assign imm16 = instr[IMM_MSB:IMM_LSB];
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed self-checking bench for ifetch (redirect cases run when IFETCH_REDIRECT_EN is defined).
module tb_ifetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        out_valid, out_ready;
    logic [31:0] instr, pc_out;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic        redirect;
    logic [31:0] redirect_pc;
    int          checks = 0;
    int          errors = 0;

    ifetch_if bus ();

    ifetch #(.PC_RESET(32'h0000_3000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instr       (instr),
        .pc_out      (pc_out),
        .op          (op),
        .funct       (funct),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm16       (imm16),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic a, input logic [31:0] d, input logic r);
        bus.ack   = a;
        bus.rdata = d;
        out_ready = r;
    endtask

    initial begin
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        drive(1'b0, '0, 1'b1);
        tick();
        check("rst_req", {31'd0, bus.req}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_req", {31'd0, bus.req}, 32'd1);
        check("addr0", bus.addr, 32'h0000_3000);
        // back-to-back fetch with decode field check
        drive(1'b1, 32'h0123_4820, 1'b1);
        tick();
        check("valid_a", {31'd0, out_valid}, 32'd1);
        check("instr_a", instr, 32'h0123_4820);
        check("pc_out_a", pc_out, 32'h0000_3000);
        check("addr1", bus.addr, 32'h0000_3004);
        check("op", {26'd0, op}, 32'd0);
        check("funct", {26'd0, funct}, 32'h20);
        check("rs", {27'd0, rs}, 32'd9);
        check("rt", {27'd0, rt}, 32'd3);
        check("rd", {27'd0, rd}, 32'd9);
        check("imm16", {16'd0, imm16}, 32'h4820);
        drive(1'b1, 32'h1111_0004, 1'b1);
        tick();
        check("instr_b", instr, 32'h1111_0004);
        check("pc_out_b", pc_out, 32'h0000_3004);
        check("addr2", bus.addr, 32'h0000_3008);
        check("req_b2b", {31'd0, bus.req}, 32'd1);
        drive(1'b0, '0, 1'b1);
        tick();
        check("valid_drain", {31'd0, out_valid}, 32'd0);
        check("addr_hold", bus.addr, 32'h0000_3008);
        // stall: ack into an occupied IR with out_ready low stops requesting
        drive(1'b1, 32'h2222_0008, 1'b1);
        tick();
        drive(1'b1, 32'h3333_000C, 1'b0);
        tick();
        check("instr_d", instr, 32'h3333_000C);
        check("pc_out_d", pc_out, 32'h0000_300C);
        check("req_stall", {31'd0, bus.req}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hDEAD_BEEF, 1'b0);
            tick();
            check("stall_instr", instr, 32'h3333_000C);
            check("stall_req", {31'd0, bus.req}, 32'd0);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        drive(1'b0, '0, 1'b1);
        tick();
        check("resume_req", {31'd0, bus.req}, 32'd1);
        check("resume_addr", bus.addr, 32'h0000_3010);
        check("resume_valid", {31'd0, out_valid}, 32'd0);
        // reset mid-request with a stale ack inside the reset window
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b1);
        tick();
        check("mid_rst_req", {31'd0, bus.req}, 32'd0);
        drive(1'b1, 32'hBAD0_BAD0, 1'b1);
        tick();
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b1);
        #1;
        check("stale_valid", {31'd0, out_valid}, 32'd0);
        check("stale_instr", instr, 32'd0);
        check("rst_addr", bus.addr, 32'h0000_3000);
        check("rst_req2", {31'd0, bus.req}, 32'd1);
        drive(1'b1, 32'h4444_0000, 1'b1);
        tick();
        check("first_ack_instr", instr, 32'h4444_0000);
        check("first_ack_pc", pc_out, 32'h0000_3000);
`ifdef IFETCH_REDIRECT_EN
        // redirect while request pending: in-flight ack dropped
        drive(1'b0, '0, 1'b1);
        redirect = 1'b1;
        redirect_pc = 32'h0000_4002;
        tick();
        redirect = 1'b0;
        check("drop_req", {31'd0, bus.req}, 32'd0);
        check("drop_valid", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 32'hBAD1_BAD1, 1'b1);
        tick();
        check("drop_discard", {31'd0, out_valid}, 32'd0);
        check("redir_addr", bus.addr, 32'h0000_4000);
        check("redir_req", {31'd0, bus.req}, 32'd1);
        drive(1'b1, 32'h5555_0000, 1'b1);
        tick();
        check("redir_instr", instr, 32'h5555_0000);
        check("redir_pc_out", pc_out, 32'h0000_4000);
        // wrap at the top of the address space
        drive(1'b0, '0, 1'b1);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        drive(1'b1, 32'hBAD2_BAD2, 1'b1);
        tick();
        check("wrap_addr0", bus.addr, 32'hFFFF_FFFC);
        drive(1'b1, 32'h6666_0000, 1'b1);
        tick();
        check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        check("wrap_addr1", bus.addr, 32'h0000_0000);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
